fsm_split: RTL and testbench
============================

# fsm_split

Input-side demultiplexer for the protobuf datapath: pops serialized message bytes from the input FIFO, parses each field key, and routes payload bytes to the varint-decode FIFO or the raw-data FIFO. Every pushed byte carries a 10-bit field index so downstream decoders can be re-ordered by field sequence. It is the receive-side counterpart of the output merge FSM, which interleaves varint and raw streams by index into the output FIFO.

## Interface
Parameters: none.
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; forces INIT
- in_fifo_empty  input  1  input FIFO has no entry
- in_fifo_q  input  8  show-ahead head byte, valid while !in_fifo_empty
- in_fifo_pop  output  1  consume head byte this cycle
- varint_fifo_full  input  1  varint FIFO cannot accept
- varint_fifo_clr  output  1  clear varint FIFO
- varint_fifo_push  output  1  write varint byte
- varint_fifo_d  output  8  varint byte (= in_fifo_q)
- varint_index_d  output  10  field index of pushed varint byte
- raw_fifo_full  input  1  raw FIFO cannot accept
- raw_fifo_clr  output  1  clear raw FIFO
- raw_fifo_push  output  1  write raw byte
- raw_fifo_d  output  8  raw byte (= in_fifo_q)
- raw_index_d  output  10  field index of pushed raw byte
- raw_last_d  output  1  pushed raw byte is last of its field
- err  output  1  protocol error, sticky
- err_clr  input  1  leave ERROR, re-initialise

## Operation
- Registers: state (one-hot), field_index[9:0], len_cnt[13:0], byte_cnt[3:0].
- INIT: varint_fifo_clr=raw_fifo_clr=1, field_index<=0; -> WAIT_KEY.
- WAIT_KEY: if !empty, pop key byte; wire type = q[2:0]. Type 0 -> VARINT, 2 -> LEN (len_cnt<=0, byte_cnt<=0), else -> ERROR. If q[7]=1, go KEY_SKIP first (wire type latched).
- KEY_SKIP: pop bytes while !empty until q[7]=0, then dispatch on latched wire type.
- VARINT: when !empty && !varint_fifo_full: pop+push, index=field_index; byte_cnt++. q[7]=0 -> field_index++, -> WAIT_KEY. q[7]=1 on 10th byte -> ERROR.
- LEN: pop length bytes (little-endian 7-bit groups) into len_cnt; max 2 bytes (14 bits); 3rd continuation -> ERROR. Final byte: len 0 -> field_index++, WAIT_KEY; else -> RAW.
- RAW: when !empty && !raw_fifo_full: pop+push, len_cnt--. raw_last_d=1 when len_cnt==1; then field_index++, -> WAIT_KEY.
- ERROR: err=1, no pops/pushes; err_clr -> INIT.
- field_index wraps 1023 -> 0. Pushed index is pre-increment value.
- Pop and push are Mealy (same cycle); pop never asserts without matching push in VARINT/RAW.
- Undefined state encoding -> INIT.

## Timing
- During reset and in INIT: *_fifo_clr=1; all other outputs 0. err=0 after reset.
- Throughput one byte/cycle; no bubble between fields except the key (and length) byte cycles.
- Backpressure: destination full holds state and all counters; pop deasserted that cycle.
- Empty input in any parse state: hold, no outputs.
- Reset mid-field: partial field abandoned; downstream FIFOs cleared via INIT.
- err_clr outside ERROR ignored.

## Configuration
- FSM_SPLIT_FIXED_EN defined: wire type 1 loads len_cnt=8, type 5 loads len_cnt=4, both go directly to RAW (no length bytes).
- Undefined: wire types 1 and 5 -> ERROR like other unsupported types.

## Test plan
- Bytes 08 96 01 -> varint pushes 96, 01 with index 0; field_index becomes 1; no raw push.
- 08 96 01 then 12 03 41 42 43 -> raw pushes 41,42,43 index 1, raw_last_d only with 43; field_index 2.
- 12 00 -> no push, field_index increments, next key accepted following cycle.
- raw_fifo_full held 5 cycles mid-field -> pop/push 0, len_cnt frozen; resume drops no bytes.
- Key 0B (type 3) -> err=1 sticky, no pops; err_clr -> clr pulse, field_index 0; with FIXED_EN, key 0D + 4 bytes -> 4 raw pushes, last flagged.
- 1025 one-byte varint fields (08 01) -> indices 0..1023, 0; reset asserted mid-RAW -> INIT, clr outputs 1.

Source files
------------

// File: rtl/fsm_split.sv
// Input-side demultiplexer: parses protobuf field keys and routes payload bytes to the
// varint or raw FIFO, tagging each byte with its field index. Option macro: FSM_SPLIT_FIXED_EN.
module fsm_split (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_fifo_empty,
  input  logic [7:0] in_fifo_q,
  output logic       in_fifo_pop,
  input  logic       varint_fifo_full,
  output logic       varint_fifo_clr,
  output logic       varint_fifo_push,
  output logic [7:0] varint_fifo_d,
  output logic [9:0] varint_index_d,
  input  logic       raw_fifo_full,
  output logic       raw_fifo_clr,
  output logic       raw_fifo_push,
  output logic [7:0] raw_fifo_d,
  output logic [9:0] raw_index_d,
  output logic       raw_last_d,
  output logic       err,
  input  logic       err_clr
);

  typedef enum logic [6:0] {
    StInit    = 7'b0000001,
    StWaitKey = 7'b0000010,
    StKeySkip = 7'b0000100,
    StVarint  = 7'b0001000,
    StLen     = 7'b0010000,
    StRaw     = 7'b0100000,
    StError   = 7'b1000000
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  field_index_q, field_index_d;
  logic [13:0] len_cnt_q, len_cnt_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [2:0]  wire_type_q, wire_type_d;

  logic        dispatch;
  logic [2:0]  disp_type;
  logic [13:0] len_new;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StInit;
      field_index_q <= '0;
      len_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      wire_type_q   <= '0;
    end else begin
      state_q       <= state_d;
      field_index_q <= field_index_d;
      len_cnt_q     <= len_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      wire_type_q   <= wire_type_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    field_index_d    = field_index_q;
    len_cnt_d        = len_cnt_q;
    byte_cnt_d       = byte_cnt_q;
    wire_type_d      = wire_type_q;
    in_fifo_pop      = 1'b0;
    varint_fifo_push = 1'b0;
    raw_fifo_push    = 1'b0;
    raw_last_d       = 1'b0;
    varint_fifo_clr  = 1'b0;
    raw_fifo_clr     = 1'b0;
    err              = 1'b0;
    dispatch         = 1'b0;
    disp_type        = wire_type_q;
    // Length is little-endian 7-bit groups; byte_cnt selects which group this byte fills.
    len_new          = (byte_cnt_q == 4'd0) ? {7'd0, in_fifo_q[6:0]}
                                            : {in_fifo_q[6:0], len_cnt_q[6:0]};

    case (state_q)
      StInit: begin
        varint_fifo_clr = 1'b1;
        raw_fifo_clr    = 1'b1;
        field_index_d   = '0;
        state_d         = StWaitKey;
      end

      StWaitKey: begin
        if (!in_fifo_empty) begin
          in_fifo_pop = 1'b1;
          wire_type_d = in_fifo_q[2:0];
          if (in_fifo_q[7]) begin
            state_d = StKeySkip;
          end else begin
            dispatch  = 1'b1;
            disp_type = in_fifo_q[2:0];
          end
        end
      end

      StKeySkip: begin
        if (!in_fifo_empty) begin
          in_fifo_pop = 1'b1;
          if (!in_fifo_q[7]) begin
            dispatch = 1'b1;
          end
        end
      end

      StVarint: begin
        if (!in_fifo_empty && !varint_fifo_full) begin
          in_fifo_pop      = 1'b1;
          varint_fifo_push = 1'b1;
          byte_cnt_d       = byte_cnt_q + 4'd1;
          if (!in_fifo_q[7]) begin
            field_index_d = field_index_q + 10'd1;
            state_d       = StWaitKey;
          end else if (byte_cnt_q == 4'd9) begin
            state_d = StError;
          end
        end
      end

      StLen: begin
        if (!in_fifo_empty) begin
          in_fifo_pop = 1'b1;
          byte_cnt_d  = byte_cnt_q + 4'd1;
          len_cnt_d   = len_new;
          if (in_fifo_q[7]) begin
            if (byte_cnt_q != 4'd0) begin
              state_d = StError;
            end
          end else if (len_new == 14'd0) begin
            field_index_d = field_index_q + 10'd1;
            state_d       = StWaitKey;
          end else begin
            state_d = StRaw;
          end
        end
      end

      StRaw: begin
        if (!in_fifo_empty && !raw_fifo_full) begin
          in_fifo_pop   = 1'b1;
          raw_fifo_push = 1'b1;
          len_cnt_d     = len_cnt_q - 14'd1;
          if (len_cnt_q == 14'd1) begin
            raw_last_d    = 1'b1;
            field_index_d = field_index_q + 10'd1;
            state_d       = StWaitKey;
          end
        end
      end

      StError: begin
        err = 1'b1;
        if (err_clr) begin
          state_d = StInit;
        end
      end

      default: begin
        state_d = StInit;
      end
    endcase

    if (dispatch) begin
      case (disp_type)
        3'd0: begin
          byte_cnt_d = '0;
          state_d    = StVarint;
        end
        3'd2: begin
          len_cnt_d  = '0;
          byte_cnt_d = '0;
          state_d    = StLen;
        end
`ifdef FSM_SPLIT_FIXED_EN
        3'd1: begin
          len_cnt_d = 14'd8;
          state_d   = StRaw;
        end
        3'd5: begin
          len_cnt_d = 14'd4;
          state_d   = StRaw;
        end
`endif
        default: begin
          state_d = StError;
        end
      endcase
    end
  end

  // Data and index are driven only alongside a push so idle outputs stay at zero.
  assign varint_fifo_d  = varint_fifo_push ? in_fifo_q : 8'd0;
  assign varint_index_d = varint_fifo_push ? field_index_q : 10'd0;
  assign raw_fifo_d     = raw_fifo_push ? in_fifo_q : 8'd0;
  assign raw_index_d    = raw_fifo_push ? field_index_q : 10'd0;

endmodule

// File: tb/tb_fsm_split.sv
// Table-driven bench for fsm_split: per-cycle input/expected-output vectors plus
// hand-written sequences for index wrap and reset mid-field.
module tb_fsm_split;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_fifo_empty;
  logic [7:0] in_fifo_q;
  logic       in_fifo_pop;
  logic       varint_fifo_full;
  logic       varint_fifo_clr;
  logic       varint_fifo_push;
  logic [7:0] varint_fifo_d;
  logic [9:0] varint_index_d;
  logic       raw_fifo_full;
  logic       raw_fifo_clr;
  logic       raw_fifo_push;
  logic [7:0] raw_fifo_d;
  logic [9:0] raw_index_d;
  logic       raw_last_d;
  logic       err;
  logic       err_clr;

  always #5 clk = ~clk;

  fsm_split dut (
    .clk              (clk),
    .reset            (reset),
    .in_fifo_empty    (in_fifo_empty),
    .in_fifo_q        (in_fifo_q),
    .in_fifo_pop      (in_fifo_pop),
    .varint_fifo_full (varint_fifo_full),
    .varint_fifo_clr  (varint_fifo_clr),
    .varint_fifo_push (varint_fifo_push),
    .varint_fifo_d    (varint_fifo_d),
    .varint_index_d   (varint_index_d),
    .raw_fifo_full    (raw_fifo_full),
    .raw_fifo_clr     (raw_fifo_clr),
    .raw_fifo_push    (raw_fifo_push),
    .raw_fifo_d       (raw_fifo_d),
    .raw_index_d      (raw_index_d),
    .raw_last_d       (raw_last_d),
    .err              (err),
    .err_clr          (err_clr)
  );

  typedef struct {
    logic       e;
    logic [7:0] q;
    logic       vf;
    logic       rf;
    logic       ec;
    logic       pop;
    logic       vp;
    logic       rp;
    logic [7:0] data;
    logic [9:0] idx;
    logic       last;
    logic       er;
    logic       clr;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic e, input logic [7:0] q, input logic vf, input logic rf,
                     input logic ec, input logic pop, input logic vp, input logic rp,
                     input logic [7:0] data, input logic [9:0] idx, input logic last,
                     input logic er, input logic clr);
    vec_t v;
    v.e = e; v.q = q; v.vf = vf; v.rf = rf; v.ec = ec;
    v.pop = pop; v.vp = vp; v.rp = rp; v.data = data; v.idx = idx;
    v.last = last; v.er = er; v.clr = clr;
    vecs.push_back(v);
  endtask

  function automatic logic [42:0] obs();
    return {in_fifo_pop, varint_fifo_push, varint_fifo_d, varint_index_d, raw_fifo_push,
            raw_fifo_d, raw_index_d, raw_last_d, err, varint_fifo_clr, raw_fifo_clr};
  endfunction

  function automatic logic [42:0] mkexp(input logic pop, input logic vp, input logic rp,
                                        input logic [7:0] data, input logic [9:0] idx,
                                        input logic last, input logic er, input logic clr);
    return {pop, vp, vp ? data : 8'h00, vp ? idx : 10'h000, rp, rp ? data : 8'h00,
            rp ? idx : 10'h000, last, er, clr, clr};
  endfunction

  task automatic check(input string name, input logic [42:0] exp);
    logic [42:0] got;
    got = obs();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [7:0] q, input logic vf, input logic rf,
                       input logic ec);
    @(negedge clk);
    in_fifo_empty    = e;
    in_fifo_q        = q;
    varint_fifo_full = vf;
    raw_fifo_full    = rf;
    err_clr          = ec;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    in_fifo_empty = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    in_fifo_empty    = 1'b1;
    in_fifo_q        = 8'h00;
    varint_fifo_full = 1'b0;
    raw_fifo_full    = 1'b0;
    err_clr          = 1'b0;

    // e    q  vf rf ec | pop vp rp data idx last err clr
    add(0, 8'h08, 0, 0, 0, 0, 0, 0, 8'h00, 10'd0, 0, 0, 1);  // INIT
    add(0, 8'h08, 0, 0, 0, 1, 0, 0, 8'h00, 10'd0, 0, 0, 0);  // key varint
    add(0, 8'h96, 0, 0, 0, 1, 1, 0, 8'h96, 10'd0, 0, 0, 0);
    add(0, 8'h01, 0, 0, 0, 1, 1, 0, 8'h01, 10'd0, 0, 0, 0);
    add(0, 8'h12, 0, 0, 0, 1, 0, 0, 8'h00, 10'd0, 0, 0, 0);  // key len
    add(0, 8'h03, 0, 0, 0, 1, 0, 0, 8'h00, 10'd0, 0, 0, 0);
    add(0, 8'h41, 0, 0, 0, 1, 0, 1, 8'h41, 10'd1, 0, 0, 0);
    add(0, 8'h42, 0, 0, 0, 1, 0, 1, 8'h42, 10'd1, 0, 0, 0);
    add(0, 8'h43, 0, 0, 0, 1, 0, 1, 8'h43, 10'd1, 1, 0, 0);
    add(1, 8'h12, 0, 0, 1, 0, 0, 0, 8'h00, 10'd0, 0, 0, 0);  // empty, err_clr ignored
    add(0, 8'h12, 0, 0, 0, 1, 0, 0, 8'h00, 10'd0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 10'd0, 0, 0, 0);  // zero length
    add(0, 8'h08, 0, 0, 0, 1, 0, 0, 8'h00, 10'd0, 0, 0, 0);
    add(0, 8'h05, 1, 0, 0, 0, 0, 0, 8'h00, 10'd0, 0, 0, 0);  // varint full
    add(0, 8'h05, 0, 0, 0, 1, 1, 0, 8'h05, 10'd3, 0, 0, 0);
    add(0, 8'h12, 0, 0, 0, 1, 0, 0, 8'h00, 10'd0, 0, 0, 0);
    add(0, 8'h02, 0, 0, 0, 1, 0, 0, 8'h00, 10'd0, 0, 0, 0);
    add(0, 8'hAA, 0, 0, 0, 1, 0, 1, 8'hAA, 10'd4, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 8'hBB, 0, 1, 0, 0, 0, 0, 8'h00, 10'd0, 0, 0, 0);
    add(0, 8'hBB, 0, 0, 0, 1, 0, 1, 8'hBB, 10'd4, 1, 0, 0);
    add(0, 8'h88, 0, 0, 0, 1, 0, 0, 8'h00, 10'd0, 0, 0, 0);  // multi-byte key
    add(0, 8'h81, 0, 0, 0, 1, 0, 0, 8'h00, 10'd0, 0, 0, 0);
    add(1, 8'h81, 0, 0, 0, 0, 0, 0, 8'h00, 10'd0, 0, 0, 0);
    add(0, 8'h01, 0, 0, 0, 1, 0, 0, 8'h00, 10'd0, 0, 0, 0);
    add(0, 8'h7F, 0, 0, 0, 1, 1, 0, 8'h7F, 10'd5, 0, 0, 0);
    add(0, 8'h0B, 0, 0, 0, 1, 0, 0, 8'h00, 10'd0, 0, 0, 0);  // unsupported type 3
    add(0, 8'h08, 0, 0, 0, 0, 0, 0, 8'h00, 10'd0, 0, 1, 0);
    add(0, 8'h08, 0, 0, 0, 0, 0, 0, 8'h00, 10'd0, 0, 1, 0);
    add(0, 8'h08, 0, 0, 1, 0, 0, 0, 8'h00, 10'd0, 0, 1, 0);
    add(0, 8'h0A, 0, 0, 0, 0, 0, 0, 8'h00, 10'd0, 0, 0, 1);  // INIT again
    add(0, 8'h0A, 0, 0, 0, 1, 0, 0, 8'h00, 10'd0, 0, 0, 0);
    add(0, 8'h80, 0, 0, 0, 1, 0, 0, 8'h00, 10'd0, 0, 0, 0);
    add(0, 8'h80, 0, 0, 0, 1, 0, 0, 8'h00, 10'd0, 0, 0, 0);  // 3rd length byte coming
    add(1, 8'h80, 0, 0, 1, 0, 0, 0, 8'h00, 10'd0, 0, 1, 0);
    add(1, 8'h0D, 0, 0, 0, 0, 0, 0, 8'h00, 10'd0, 0, 0, 1);
    add(0, 8'h0D, 0, 0, 0, 1, 0, 0, 8'h00, 10'd0, 0, 0, 0);  // key type 5
`ifdef FSM_SPLIT_FIXED_EN
    add(0, 8'h11, 0, 0, 0, 1, 0, 1, 8'h11, 10'd0, 0, 0, 0);
    add(0, 8'h12, 0, 0, 0, 1, 0, 1, 8'h12, 10'd0, 0, 0, 0);
    add(0, 8'h13, 0, 0, 0, 1, 0, 1, 8'h13, 10'd0, 0, 0, 0);
    add(0, 8'h14, 0, 0, 0, 1, 0, 1, 8'h14, 10'd0, 1, 0, 0);
    add(1, 8'h14, 0, 0, 0, 0, 0, 0, 8'h00, 10'd0, 0, 0, 0);
`else
    add(0, 8'h11, 0, 0, 0, 0, 0, 0, 8'h00, 10'd0, 0, 1, 0);
    add(1, 8'h11, 0, 0, 1, 0, 0, 0, 8'h00, 10'd0, 0, 1, 0);
    add(1, 8'h11, 0, 0, 0, 0, 0, 0, 8'h00, 10'd0, 0, 0, 1);
`endif

    #1;
    check("reset_state", mkexp(0, 0, 0, 8'h00, 10'd0, 0, 0, 1));
    in_fifo_empty = 1'b0;
    in_fifo_q     = 8'h08;
    #1;
    check("reset_no_pop", mkexp(0, 0, 0, 8'h00, 10'd0, 0, 0, 1));
    @(posedge clk);
    #2 reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].e, vecs[i].q, vecs[i].vf, vecs[i].rf, vecs[i].ec);
      check($sformatf("vec%0d", i), mkexp(vecs[i].pop, vecs[i].vp, vecs[i].rp, vecs[i].data,
                                          vecs[i].idx, vecs[i].last, vecs[i].er, vecs[i].clr));
    end

    // 1025 one-byte varint fields: index wraps 1023 -> 0.
    do_reset();
    drive(1, 8'h00, 0, 0, 0);
    check("wrap_init", mkexp(0, 0, 0, 8'h00, 10'd0, 0, 0, 1));
    for (int i = 0; i < 1025; i++) begin
      logic [9:0] exp_idx;
      exp_idx = 10'(i);
      drive(0, 8'h08, 0, 0, 0);
      check($sformatf("wrap_key%0d", i), mkexp(1, 0, 0, 8'h00, 10'd0, 0, 0, 0));
      drive(0, 8'h01, 0, 0, 0);
      check($sformatf("wrap_val%0d", i), mkexp(1, 1, 0, 8'h01, exp_idx, 0, 0, 0));
    end

    // Reset asserted mid-RAW field.
    drive(0, 8'h12, 0, 0, 0);
    check("mid_key", mkexp(1, 0, 0, 8'h00, 10'd0, 0, 0, 0));
    drive(0, 8'h03, 0, 0, 0);
    check("mid_len", mkexp(1, 0, 0, 8'h00, 10'd0, 0, 0, 0));
    drive(0, 8'h41, 0, 0, 0);
    check("mid_raw", mkexp(0, 0, 1, 8'h41, 10'd1, 0, 0, 0) | (43'd1 << 42));
    @(negedge clk);
    in_fifo_q = 8'h42;
    #2 reset = 1'b1;
    #1;
    check("mid_reset", mkexp(0, 0, 0, 8'h00, 10'd0, 0, 0, 1));
    @(posedge clk);
    #2 reset = 1'b0;
    drive(0, 8'h08, 0, 0, 0);
    check("post_init", mkexp(0, 0, 0, 8'h00, 10'd0, 0, 0, 1));
    drive(0, 8'h08, 0, 0, 0);
    check("post_key", mkexp(1, 0, 0, 8'h00, 10'd0, 0, 0, 0));
    drive(0, 8'h01, 0, 0, 0);
    check("post_idx", mkexp(1, 1, 0, 8'h01, 10'd0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
